// File: rtl/io_input_responder.sv
// Responder for the CPU IN handshake: debounced button, switch sampling and decimal entry.
// Collected digits are returned on in_data/in_valid and echoed as BCD for the displays.
module io_input_responder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_DIGITS      = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_raw,
   input  logic [3:0]        sw,
   input  logic              in_req,
   input  logic              in_ack,
   output logic [DATA_W-1:0] in_data,
   output logic              in_valid,
   output logic              busy,
   output logic [3:0]        echo_uni,
   output logic [3:0]        echo_dez,
   output logic [3:0]        echo_cen,
   output logic [1:0]        digit_count,
   output logic              press_pulse,
   output logic              err_pulse
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned AccW = 10;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] MaxCnt = 2'(MAX_DIGITS);

   typedef enum logic [1:0] {StIdle, StCollect, StValid} state_e;

   state_e          state_q, state_d;
   logic            btn_s1_q, btn_s2_q;
   logic [3:0]      sw_s1_q, sw_s2_q;
   logic [CntW-1:0] db_cnt_q, db_cnt_d;
   logic            db_level_q, db_level_d;
   logic            db_prev_q;
   logic            press_q, press_d;
   logic            err_q, err_d;
   logic            req_prev_q;
   logic [AccW-1:0] acc_q, acc_d;
   logic [1:0]      dc_q, dc_d;
   logic [1:0]      dc_inc;
   logic            req_rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         db_cnt_q   <= '0;
         db_level_q <= 1'b0;
         db_prev_q  <= 1'b0;
         press_q    <= 1'b0;
         err_q      <= 1'b0;
         req_prev_q <= 1'b0;
         acc_q      <= '0;
         dc_q       <= '0;
      end else begin
         state_q    <= state_d;
         btn_s1_q   <= btn_raw;
         btn_s2_q   <= btn_s1_q;
         sw_s1_q    <= sw;
         sw_s2_q    <= sw_s1_q;
         db_cnt_q   <= db_cnt_d;
         db_level_q <= db_level_d;
         db_prev_q  <= db_level_q;
         press_q    <= press_d;
         err_q      <= err_d;
         req_prev_q <= in_req;
         acc_q      <= acc_d;
         dc_q       <= dc_d;
      end
   end

   // Counter runs only while the synced input disagrees with the accepted level;
   // any agreeing sample (i.e. a bounce back) restarts the qualification window.
   always_comb begin
      db_cnt_d   = '0;
      db_level_d = db_level_q;
      if (btn_s2_q != db_level_q) begin
         if (db_cnt_q == CntLast) begin
            db_level_d = btn_s2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      press_d = db_level_q & ~db_prev_q;
   end

   assign req_rise = in_req & ~req_prev_q;
   assign dc_inc   = dc_q + 2'd1;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dc_d    = dc_q;
      err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_rise) begin
               state_d = StCollect;
               acc_d   = '0;
               dc_d    = '0;
            end
         end
         StCollect: begin
            if (!in_req) begin
               state_d = StIdle;
               acc_d   = '0;
               dc_d    = '0;
            end else if (press_q) begin
               if (sw_s2_q <= 4'd9) begin
                  acc_d = acc_q * AccW'(10) + AccW'(sw_s2_q);
                  dc_d  = dc_inc;
                  if (dc_inc == MaxCnt) begin
                     state_d = StValid;
                  end
               end else if (sw_s2_q == 4'hF) begin
                  state_d = StValid;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StValid: begin
            if (in_ack || !in_req) begin
               state_d = StIdle;
               acc_d   = '0;
               dc_d    = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign in_data     = DATA_W'(acc_q);
   assign in_valid    = (state_q == StValid);
   assign busy        = (state_q == StCollect);
   assign digit_count = dc_q;
   assign press_pulse = press_q;
   assign err_pulse   = err_q;

   // acc is capped at 999, so the hundreds digit always fits in 4 bits.
   assign echo_cen = 4'(acc_q / AccW'(100));
   assign echo_dez = 4'((acc_q / AccW'(10)) % AccW'(10));
   assign echo_uni = 4'(acc_q % AccW'(10));

endmodule
